// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: dequeue-mode constants and FSM state encodings shared by the issue controller
package issue_ctrl_pkg;
  localparam logic [1:0] ISSUE_NONE   = 2'b00;
  localparam logic [1:0] ISSUE_SINGLE = 2'b01;
  localparam logic [1:0] ISSUE_DUAL   = 2'b11;
  typedef enum logic [1:0] {
    IC_NORMAL  = 2'd0,
    IC_DS_ONLY = 2'd1,
    IC_SERIAL  = 2'd2
  } ic_state_e;
endpackage

// File: rtl/issue_pair_check.sv
// issue_pair_check: decides whether slot1 is hazard-free and may issue alongside slot0
module issue_pair_check (
  input  logic [1:0] sv,
  input  logic       exc1,
  input  logic       priv1,
  input  logic       br1,
  input  logic       raw,
  input  logic       sc,
  output logic       slot1_clean,
  output logic       can_pair
);
  assign slot1_clean = (sv == 2'b11) && !exc1 && !priv1 && !raw && !sc;
  // a branch in slot1 would separate from its delay slot, so it never pairs behind a plain slot0
  assign can_pair    = slot1_clean && !br1;
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: picks 0/1/2 instructions to issue per cycle; ISSUE_PERF_CNT_EN adds dual/single/bubble counters
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SBA_flush_w_i,
  input  logic              CP0_excOccur_w_i,
  input  logic [1:0]        IQ_supplyValid_i,
  input  logic [1:0]        IQ_hasException_i,
  input  logic [1:0]        ID_isBranch_i,
  input  logic [1:0]        ID_isPriv_i,
  input  logic              ID_raw_i,
  input  logic              ID_structConflict_i,
  input  logic              EXE_ready_i,
  input  logic              EXE_drained_i,
  output logic [1:0]        ID_upDateMode_o,
  output logic [1:0]        ID_issueValid_o,
  output logic [1:0]        ID_state_o,
  output logic [PERF_W-1:0] ID_dualCnt_o,
  output logic [PERF_W-1:0] ID_singleCnt_o,
  output logic [PERF_W-1:0] ID_bubbleCnt_o
);
  ic_state_e  state_q, state_d, cur;
  logic [1:0] mode, sv;
  logic       flush, slot1_clean, can_pair;
  assign sv    = IQ_supplyValid_i;
  assign flush = SBA_flush_w_i || CP0_excOccur_w_i;
  assign cur   = rst ? state_q : IC_NORMAL;
  issue_pair_check u_pair (
    .sv          (sv),
    .exc1        (IQ_hasException_i[1]),
    .priv1       (ID_isPriv_i[1]),
    .br1         (ID_isBranch_i[1]),
    .raw         (ID_raw_i),
    .sc          (ID_structConflict_i),
    .slot1_clean (slot1_clean),
    .can_pair    (can_pair)
  );
  // flush beats backpressure, which beats the per-state issue rules
  always_comb begin
    mode    = ISSUE_NONE;
    state_d = cur;
    if (flush) begin
      state_d = IC_NORMAL;
    end else if (EXE_ready_i) begin
      case (cur)
        IC_NORMAL: begin
          if (sv == 2'b00) mode = ISSUE_NONE;
          else if (IQ_hasException_i[0]) mode = ISSUE_SINGLE;
          else if (ID_isPriv_i[0]) begin
            mode    = ISSUE_SINGLE;
            state_d = IC_SERIAL;
          end else if (ID_isBranch_i[0]) begin
            mode    = (sv == 2'b11) ? (slot1_clean ? ISSUE_DUAL : ISSUE_SINGLE) : ISSUE_NONE;
            state_d = (sv == 2'b11 && !slot1_clean) ? IC_DS_ONLY : IC_NORMAL;
          end else mode = can_pair ? ISSUE_DUAL : ISSUE_SINGLE;
        end
        IC_DS_ONLY: begin
          mode    = (sv != 2'b00) ? ISSUE_SINGLE : ISSUE_NONE;
          state_d = (sv == 2'b00) ? IC_DS_ONLY :
                    (ID_isPriv_i[0] && !IQ_hasException_i[0]) ? IC_SERIAL : IC_NORMAL;
        end
        IC_SERIAL: state_d = EXE_drained_i ? IC_NORMAL : IC_SERIAL;
        default:   state_d = IC_NORMAL;
      endcase
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IC_NORMAL;
    else      state_q <= state_d;
  end
  assign ID_upDateMode_o = mode;
  assign ID_issueValid_o = mode;
  assign ID_state_o      = state_q;
`ifdef ISSUE_PERF_CNT_EN
  logic [PERF_W-1:0] dual_q, dual_d, single_q, single_d, bubble_q, bubble_d;
  // wrap-around usage counters; flushes leave them untouched
  always_comb begin
    dual_d   = dual_q + PERF_W'(mode == ISSUE_DUAL);
    single_d = single_q + PERF_W'(mode == ISSUE_SINGLE);
    bubble_d = bubble_q + PERF_W'(sv != 2'b00 && EXE_ready_i && !flush && mode == ISSUE_NONE);
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      dual_q   <= '0;
      single_q <= '0;
      bubble_q <= '0;
    end else begin
      dual_q   <= dual_d;
      single_q <= single_d;
      bubble_q <= bubble_d;
    end
  end
  assign ID_dualCnt_o   = dual_q;
  assign ID_singleCnt_o = single_q;
  assign ID_bubbleCnt_o = bubble_q;
`else
  assign ID_dualCnt_o   = '0;
  assign ID_singleCnt_o = '0;
  assign ID_bubbleCnt_o = '0;
`endif
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scoreboard bench for issue_ctrl
module tb_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst, sba, cp0, raw, sc, rdy, drn;
  logic [1:0]  sv, exc, br, pr;
  logic [1:0]  mode_o, valid_o, state_o;
  logic [31:0] dual_o, single_o, bubble_o;
  logic [31:0] m_dual, m_single, m_bub;
  int          vectors = 0, miscompares = 0;
  typedef struct packed {logic [1:0] mode; logic [1:0] st;} exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  issue_ctrl #(.PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .SBA_flush_w_i(sba), .CP0_excOccur_w_i(cp0),
    .IQ_supplyValid_i(sv), .IQ_hasException_i(exc),
    .ID_isBranch_i(br), .ID_isPriv_i(pr),
    .ID_raw_i(raw), .ID_structConflict_i(sc),
    .EXE_ready_i(rdy), .EXE_drained_i(drn),
    .ID_upDateMode_o(mode_o), .ID_issueValid_o(valid_o), .ID_state_o(state_o),
    .ID_dualCnt_o(dual_o), .ID_singleCnt_o(single_o), .ID_bubbleCnt_o(bubble_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_cnt(input string tag);
`ifdef ISSUE_PERF_CNT_EN
    chk({tag, ".dual"}, dual_o, m_dual);
    chk({tag, ".single"}, single_o, m_single);
    chk({tag, ".bubble"}, bubble_o, m_bub);
`else
    chk({tag, ".cnt"}, dual_o | single_o | bubble_o, 32'd0);
`endif
  endtask
  task automatic step(input string tag, input logic [1:0] s, x, b, p,
                      input logic rw, st, rd, dr, f0, f1,
                      input logic [1:0] em, es);
    @(negedge clk);
    sv = s; exc = x; br = b; pr = p; raw = rw; sc = st; rdy = rd; drn = dr; sba = f0; cp0 = f1;
    sb.push_back('{mode: em, st: es});
    if (em == 2'b11) m_dual++;
    if (em == 2'b01) m_single++;
    if (s != 2'b00 && rd && !f0 && !f1 && em == 2'b00) m_bub++;
    #1;
    e = sb.pop_front();
    chk({tag, ".mode"}, 32'(mode_o), 32'(e.mode));
    chk({tag, ".valid"}, 32'(valid_o), 32'(e.mode));
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(e.st));
    chk_cnt(tag);
  endtask
  initial begin
    rst = 1'b0; sba = 0; cp0 = 0; raw = 0; sc = 0; rdy = 1; drn = 0;
    sv = 0; exc = 0; br = 0; pr = 0;
    m_dual = 0; m_single = 0; m_bub = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.state", 32'(state_o), 32'd0);
    chk_cnt("reset");
    @(negedge clk);
    rst = 1'b1;
    //    tag          sv     exc    br     pr     raw sc rdy drn sba cp0 mode   next
    step("dual0",     2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b11, 2'd0);
    step("dual1",     2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b11, 2'd0);
    step("idle",      2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'd0);
    step("br_wait",   2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'd0);
    step("br_pair",   2'b11, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 2'b11, 2'd0);
    step("br_raw",    2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0, 2'b01, 2'd1);
    step("ds_issue",  2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b01, 2'd0);
    step("priv",      2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 2'b01, 2'd2);
    step("ser_w0",    2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'd2);
    step("ser_w1",    2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'd2);
    step("ser_w2",    2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'd2);
    step("ser_drain", 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 2'b00, 2'd0);
    step("post_ser",  2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b11, 2'd0);
    step("br_sc",     2'b11, 2'b00, 2'b01, 2'b00, 0, 1, 1, 0, 0, 0, 2'b01, 2'd1);
    step("ds_flush",  2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 2'b00, 2'd0);
    step("exc_wins",  2'b11, 2'b01, 2'b01, 2'b01, 0, 0, 1, 0, 0, 0, 2'b01, 2'd0);
    step("s1_branch", 2'b11, 2'b00, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0, 2'b01, 2'd0);
    step("s1_exc",    2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b01, 2'd0);
    step("s1_priv",   2'b11, 2'b00, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0, 2'b01, 2'd0);
    step("bp_norm",   2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0);
    step("to_ds",     2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0, 2'b01, 2'd1);
    step("bp_ds",     2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'd1);
    step("ds_empty",  2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'd1);
    step("ds_priv",   2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 2'b01, 2'd2);
    step("ser_bp",    2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'd2);
    // reset while serializing: outputs decode as NORMAL, state and counters clear
    @(negedge clk);
    rst = 1'b0; sv = 2'b11; exc = 0; br = 0; pr = 0; raw = 0; sc = 0; rdy = 1; drn = 0;
    #1;
    chk("rst_ser.mode", 32'(mode_o), 32'(2'b11));
    @(posedge clk);
    #1;
    m_dual = 0; m_single = 0; m_bub = 0;
    chk("rst_ser.state", 32'(state_o), 32'd0);
    chk_cnt("rst_ser");
    @(negedge clk);
    rst = 1'b1;
    step("drn_norm",  2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 2'b01, 2'd0);
    step("cp0_flush", 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 1, 2'b00, 2'd0);
    step("to_ds2",    2'b11, 2'b00, 2'b01, 2'b00, 0, 1, 1, 0, 0, 0, 2'b01, 2'd1);
    step("ds_pexc",   2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 2'b01, 2'd0);
    step("priv_fl",   2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 1, 0, 2'b00, 2'd0);
    step("single",    2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b01, 2'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue controller between the instruction queue and the decode/issue stage. Each cycle it inspects the up-to-two head instructions, their pairing hazards and backend readiness. It then decides whether to issue zero, one or two instructions, driving the queue's dequeue mode. A small state machine keeps branches paired with their delay slots and serializes privileged instructions.

## Interface
Parameters:
- `PERF_W`, 32, width of each performance counter (used only when `ISSUE_PERF_CNT_EN` is defined)

Ports:
- `clk`  in  1  single clock, all state on posedge
- `rst`  in  1  synchronous, active-low reset
- `SBA_flush_w_i`  in  1  branch-mispredict flush
- `CP0_excOccur_w_i`  in  1  exception flush
- `IQ_supplyValid_i`  in  2  queue head occupancy: 00 none, 01 slot0 only, 11 both slots
- `IQ_hasException_i`  in  2  per-slot fetch exception
- `ID_isBranch_i`  in  2  per-slot branch/jump, with a delay slot
- `ID_isPriv_i`  in  2  per-slot serializing instruction (mtc0, eret, syscall, break, tlb*, cache)
- `ID_raw_i`  in  1  slot1 reads slot0's destination
- `ID_structConflict_i`  in  1  slots need the same single-copy unit
- `EXE_ready_i`  in  1  issue registers can accept this cycle
- `EXE_drained_i`  in  1  backend empty; no serializing instruction in flight
- `ID_upDateMode_o`  out  2  dequeue count to queue: 00, 01 or 11; combinational
- `ID_issueValid_o`  out  2  slot valid into the issue register; equals `ID_upDateMode_o`
- `ID_state_o`  out  2  current FSM state (debug)
- `ID_dualCnt_o`, `ID_singleCnt_o`, `ID_bubbleCnt_o`  out  `PERF_W` each  performance counters (macro-gated)

## Operation
- FSM states:
  - NORMAL = 2'd0
  - DS_ONLY = 2'd1: branch was issued alone; slot0 now holds its delay slot
  - SERIAL = 2'd2: serializing instruction issued; waiting for drain
- Priority:
  1. Flush: either flush input high → mode 00; next state NORMAL.
  2. Not ready: `EXE_ready_i` = 0 → mode 00; state holds.
  3. State rules below.
- NORMAL, `sv` = `IQ_supplyValid_i`:
  - `sv` = 00 → 00.
  - slot0 exception → 01; stay NORMAL. Exception beats branch/priv.
  - slot0 priv → 01; go SERIAL.
  - slot0 branch, `sv` = 01 → 00. Wait for the delay slot; counts as a bubble.
  - slot0 branch, `sv` = 11, slot1 clean → 11. Clean means no exception, no priv, no raw, no struct conflict.
  - slot0 branch, `sv` = 11, slot1 not clean → 01; go DS_ONLY.
  - slot0 plain, `sv` = 11, slot1 clean and not branch → 11.
  - slot0 plain otherwise → 01. A branch in slot1 is never paired with slot0.
- DS_ONLY:
  - `sv` ≠ 00 → 01. Next state SERIAL if slot0 is priv and has no exception, else NORMAL.
  - `sv` = 00 → 00; hold.
- SERIAL:
  - mode 00 every cycle.
  - `EXE_drained_i` = 1 → next state NORMAL; the next issue happens one cycle later.
- `ID_upDateMode_o` is only ever 00, 01 or 11; 10 is never driven.

## Timing
- Mode outputs are combinational from the registered state plus the current inputs, with zero-cycle latency. The queue applies the mode at the same clock edge.
- State updates on posedge.
- Reset (`rst` = 0 at posedge): state NORMAL; all counters 0.
- During reset, outputs decode from NORMAL and inputs; the queue ignores them while in reset.
- A flush coinciding with any issue condition: flush wins, mode 00.
- Reset mid-SERIAL or mid-DS_ONLY → NORMAL the next cycle.
- An `EXE_drained_i` pulse while the state is not SERIAL is ignored.

## Configuration
- `ISSUE_PERF_CNT_EN` defined: three `PERF_W` wrap-around counters.
  - dual: +1 per cycle with mode 11.
  - single: +1 per cycle with mode 01.
  - bubble: +1 per cycle with `sv` ≠ 00, `EXE_ready_i` = 1, no flush, mode 00.
- Counters reset to 0; they do not clear on flush.
- `ISSUE_PERF_CNT_EN` undefined: counter outputs tied to 0; no counter flops.

## Structure
- Shared defines header holds:
  - mode constants: `ISSUE_NONE` 2'b00, `ISSUE_SINGLE` 2'b01, `ISSUE_DUAL` 2'b11
  - state encodings: `IC_NORMAL`, `IC_DS_ONLY`, `IC_SERIAL`
- One combinational sub-module, `issue_pair_check`: computes slot1-clean and can-pair from per-slot flags, raw and struct.
- FSM, priority mux and counters live in `issue_ctrl`.

## Test plan
- Dual pair: `sv` = 11, no hazards, ready → mode 11 each cycle; dual counter increments by 1 per cycle.
- Branch waits for delay slot: `sv` = 01, slot0 branch → mode 00 and bubble +1. Next cycle `sv` = 11, clean → mode 11.
- Branch plus conflicting delay slot: `sv` = 11, slot0 branch, `ID_raw_i` = 1 → mode 01, state DS_ONLY. Next cycle `sv` = 01 → mode 01, state NORMAL.
- Serialize: slot0 priv → mode 01, state SERIAL. Three cycles with `EXE_drained_i` = 0 → mode 00. Drain pulse → NORMAL. The following cycle, `sv` = 11 → 11.
- Flush priority: in DS_ONLY with `sv` = 01, assert `SBA_flush_w_i` → mode 00; next state NORMAL.
- Backpressure and reset: `EXE_ready_i` = 0 with `sv` = 11 → mode 00, state unchanged. Drive `rst` = 0 while in SERIAL → state NORMAL and all counters 0 after the edge.
